// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_sb_pkg;
    localparam int WORD_SIZE_DEF = 19;
    localparam int NUM_REGS_DEF  = 8;
    localparam int ADDR_W_DEF    = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_sb_sb_bits.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
module reg_sb_bits
    import reg_file_sb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                set_en_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                unset_en_i,
    input  logic [ADDR_W-1:0]   unset_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Set is applied after clear so a same-cycle lock keeps the new producer pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (unset_en_i && legal(unset_addr_i) && (32'(unset_addr_i) == i))
                    busy_d[i] = 1'b0;
                if (set_en_i && legal(set_addr_i) && (32'(set_addr_i) == i))
                    busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with one write port, two registered read ports,
// write-first forwarding and a per-register busy scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int ZERO_REG  = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 WR_EN,
    input  logic [ADDR_W-1:0]    WR_ADDR,
    input  logic [WORD_SIZE-1:0] WR_DATA,
    input  logic [ADDR_W-1:0]    RD_ADDR_A,
    output logic [WORD_SIZE-1:0] RD_DATA_A,
    input  logic [ADDR_W-1:0]    RD_ADDR_B,
    output logic [WORD_SIZE-1:0] RD_DATA_B,
    input  logic                 LOCK_EN,
    input  logic [ADDR_W-1:0]    LOCK_ADDR,
    output logic                 BUSY_A,
    output logic                 BUSY_B,
    input  logic                 CLR
);

    logic [WORD_SIZE-1:0] mem_q [NUM_REGS];
    logic [WORD_SIZE-1:0] mem_d [NUM_REGS];
    logic [WORD_SIZE-1:0] rd_a_q, rd_a_d;
    logic [WORD_SIZE-1:0] rd_b_q, rd_b_d;
    logic [NUM_REGS-1:0]  busy;
    logic                 wr_ok;
    logic                 fwd_a, fwd_b;

    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = WR_EN && legal(WR_ADDR);
    assign fwd_a = wr_ok && (WR_ADDR == RD_ADDR_A);
    assign fwd_b = wr_ok && (WR_ADDR == RD_ADDR_B);

    always_comb begin
        mem_d = mem_q;
        if (CLR) begin
            for (int i = 0; i < NUM_REGS; i++) mem_d[i] = '0;
        end else if (wr_ok) begin
            mem_d[WR_ADDR] = WR_DATA;
        end
    end

    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        if (!CLR) begin
            if (fwd_a)                 rd_a_d = WR_DATA;
            else if (legal(RD_ADDR_A)) rd_a_d = mem_q[RD_ADDR_A];
            if (fwd_b)                 rd_b_d = WR_DATA;
            else if (legal(RD_ADDR_B)) rd_b_d = mem_q[RD_ADDR_B];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            mem_q  <= mem_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    reg_sb_bits #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i        (CLK),
        .rst_ni       (RST_N),
        .clr_i        (CLR),
        .set_en_i     (LOCK_EN),
        .set_addr_i   (LOCK_ADDR),
        .unset_en_i   (wr_ok),
        .unset_addr_i (WR_ADDR),
        .busy_o       (busy)
    );

    // A register written this cycle is consumable via the forwarding path.
    assign BUSY_A = legal(RD_ADDR_A) && busy[RD_ADDR_A] && !fwd_a;
    assign BUSY_B = legal(RD_ADDR_B) && busy[RD_ADDR_B] && !fwd_b;

    assign RD_DATA_A = rd_a_q;
    assign RD_DATA_B = rd_b_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed checks of reg_file_sb in both ZERO_REG builds
// against a behavioural model.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        WR_EN = 1'b0;
    reg_addr_t   WR_ADDR = '0;
    logic [18:0] WR_DATA = '0;
    reg_addr_t   RD_ADDR_A = '0;
    reg_addr_t   RD_ADDR_B = '0;
    logic        LOCK_EN = 1'b0;
    reg_addr_t   LOCK_ADDR = '0;
    logic        CLR = 1'b0;

    logic [18:0] rda [2];
    logic [18:0] rdb [2];
    logic        bsa [2];
    logic        bsb [2];

    int n_chk = 0;
    int n_fail = 0;

    logic [18:0] m_reg [2][8];
    logic        m_busy [2][8];
    logic [18:0] m_rd [2][2];

    always #5 CLK = ~CLK;

    reg_file_sb #(.ZERO_REG(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .RD_ADDR_A(RD_ADDR_A), .RD_DATA_A(rda[0]),
        .RD_ADDR_B(RD_ADDR_B), .RD_DATA_B(rdb[0]), .LOCK_EN(LOCK_EN),
        .LOCK_ADDR(LOCK_ADDR), .BUSY_A(bsa[0]), .BUSY_B(bsb[0]), .CLR(CLR)
    );

    reg_file_sb #(.ZERO_REG(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .RD_ADDR_A(RD_ADDR_A), .RD_DATA_A(rda[1]),
        .RD_ADDR_B(RD_ADDR_B), .RD_DATA_B(rdb[1]), .LOCK_EN(LOCK_EN),
        .LOCK_ADDR(LOCK_ADDR), .BUSY_A(bsa[1]), .BUSY_B(bsb[1]), .CLR(CLR)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < 2; v++) begin
            for (int r = 0; r < 8; r++) begin
                m_reg[v][r]  = '0;
                m_busy[v][r] = 1'b0;
            end
            m_rd[v][0] = '0;
            m_rd[v][1] = '0;
        end
    endfunction

    // A write lands unless it targets r0 in the hard-wired-zero build.
    function automatic bit wr_lands(int v);
        return WR_EN && !(v == 1 && WR_ADDR == 0);
    endfunction

    function automatic logic exp_busy(int v, int r);
        if (v == 1 && r == 0) return 1'b0;
        if (wr_lands(v) && int'(WR_ADDR) == r) return 1'b0;
        return m_busy[v][r];
    endfunction

    function automatic logic [18:0] exp_read(int v, int r);
        if (v == 1 && r == 0) return '0;
        if (wr_lands(v) && int'(WR_ADDR) == r) return WR_DATA;
        return m_reg[v][r];
    endfunction

    function automatic void model_edge();
        for (int v = 0; v < 2; v++) begin
            if (CLR) begin
                for (int r = 0; r < 8; r++) begin
                    m_reg[v][r]  = '0;
                    m_busy[v][r] = 1'b0;
                end
                m_rd[v][0] = '0;
                m_rd[v][1] = '0;
            end else begin
                m_rd[v][0] = exp_read(v, int'(RD_ADDR_A));
                m_rd[v][1] = exp_read(v, int'(RD_ADDR_B));
                if (wr_lands(v)) begin
                    m_reg[v][WR_ADDR]  = WR_DATA;
                    m_busy[v][WR_ADDR] = 1'b0;
                end
                if (LOCK_EN && !(v == 1 && LOCK_ADDR == 0))
                    m_busy[v][LOCK_ADDR] = 1'b1;
            end
        end
    endfunction

    task automatic cyc(input bit we, input int wa, input logic [18:0] wd,
                       input int ra, input int rb, input bit le,
                       input int la, input bit cl);
        @(negedge CLK);
        WR_EN = we; WR_ADDR = reg_addr_t'(wa); WR_DATA = wd;
        RD_ADDR_A = reg_addr_t'(ra); RD_ADDR_B = reg_addr_t'(rb);
        LOCK_EN = le; LOCK_ADDR = reg_addr_t'(la); CLR = cl;
        #1;
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("busyA_z%0d", v), 32'(bsa[v]), 32'(exp_busy(v, ra)));
            chk($sformatf("busyB_z%0d", v), 32'(bsb[v]), 32'(exp_busy(v, rb)));
        end
        @(posedge CLK);
        model_edge();
        #1;
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("rdA_z%0d", v), 32'(rda[v]), 32'(m_rd[v][0]));
            chk($sformatf("rdB_z%0d", v), 32'(rdb[v]), 32'(m_rd[v][1]));
        end
    endtask

    task automatic idle_inputs();
        WR_EN = 1'b0; LOCK_EN = 1'b0; CLR = 1'b0;
    endtask

    // Reset is dropped a little after an edge so its effect is seen before the next one.
    task automatic mid_reset();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("rst_rdA_z%0d", v), 32'(rda[v]), 32'(0));
            chk($sformatf("rst_rdB_z%0d", v), 32'(rdb[v]), 32'(0));
            chk($sformatf("rst_bsA_z%0d", v), 32'(bsa[v]), 32'(0));
            chk($sformatf("rst_bsB_z%0d", v), 32'(bsb[v]), 32'(0));
        end
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int a = 0; a < 8; a++) cyc(0, 0, 0, a, 7 - a, 0, 0, 0);

        cyc(1, 3, 19'h5A5A5, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 3, 3, 0, 0, 0);
        chk("r3_latency", 32'(rda[0]), 32'h5A5A5);
        chk("r3_same_port", 32'(rdb[0]), 32'h5A5A5);

        cyc(0, 0, 0, 0, 2, 1, 2, 0);
        cyc(1, 2, 19'h7FFFF, 0, 2, 0, 0, 0);
        chk("fwd_r2", 32'(rdb[0]), 32'h7FFFF);

        cyc(0, 0, 0, 5, 5, 1, 5, 0);
        cyc(1, 5, 19'h00123, 5, 5, 1, 5, 0);
        cyc(0, 0, 0, 5, 5, 0, 0, 0);
        chk("r5_lock_wins", 32'(bsa[0]), 32'(1));
        cyc(1, 5, 19'h00456, 5, 5, 0, 0, 0);
        cyc(0, 0, 0, 5, 5, 0, 0, 0);
        chk("r5_unlocked", 32'(bsa[0]), 32'(0));

        cyc(1, 0, 19'h00001, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_reg_rd", 32'(rda[1]), 32'(0));
        chk("zero_reg_busy", 32'(bsa[1]), 32'(0));
        chk("plain_r0_rd", 32'(rda[0]), 32'h00001);
        chk("plain_r0_busy", 32'(bsa[0]), 32'(1));

        for (int r = 1; r < 8; r++) cyc(1, r, 19'(r * 4099), r, 0, 0, 0, 0);
        cyc(0, 0, 0, 4, 6, 1, 4, 0);
        mid_reset();
        for (int a = 0; a < 8; a++) cyc(0, 0, 0, a, a, 0, 0, 0);

        cyc(1, 6, 19'h3C3C3, 6, 6, 0, 0, 0);
        cyc(1, 6, 19'h12345, 6, 6, 1, 6, 1);
        cyc(0, 0, 0, 6, 6, 0, 0, 0);
        chk("clr_r6_rd", 32'(rda[0]), 32'(0));
        chk("clr_r6_busy", 32'(bsa[0]), 32'(0));

        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                19'($urandom), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), bit'($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 7)), bit'($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file replacing the discrete A–C registers of the 19-bit CPU.
- Provides one write port and two registered read ports, with write-to-read forwarding.
- Holds a per-register busy scoreboard so that decode can stall on pending writes.
- Sits between decode (read/lock) and writeback (write/unlock).

Parameters:
- WORD_SIZE, 19, data width of each register.
- NUM_REGS, 8, number of architectural registers; must be at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width.
- ZERO_REG, 0, when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  writeback write enable.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  WORD_SIZE  write data.
- RD_ADDR_A  in  ADDR_W  read port A address.
- RD_DATA_A  out  WORD_SIZE  registered read data, port A.
- RD_ADDR_B  in  ADDR_W  read port B address.
- RD_DATA_B  out  WORD_SIZE  registered read data, port B.
- LOCK_EN  in  1  decode marks LOCK_ADDR busy (pending write).
- LOCK_ADDR  in  ADDR_W  register to lock.
- BUSY_A  out  1  combinational: register at RD_ADDR_A has a pending write.
- BUSY_B  out  1  combinational: register at RD_ADDR_B has a pending write.
- CLR  in  1  synchronous clear: all registers to 0 and all busy bits to 0.

Behaviour:
- Reset is asynchronous on RST_N low. All registers go to 0, all busy bits to 0, and RD_DATA_A/B go to 0.
  - Reset takes effect mid-operation regardless of the other inputs.
  - The first capture happens on the first posedge after RST_N rises.
- Write: on posedge with WR_EN=1, reg[WR_ADDR] <= WR_DATA. Writes are dropped if WR_ADDR >= NUM_REGS, or if ZERO_REG=1 and WR_ADDR=0.
- Read: on every posedge, RD_DATA_x <= reg[RD_ADDR_x]. Latency is 1 cycle; there is no hold/enable, so the outputs track the address registered each cycle.
- Forwarding: if WR_EN=1 and WR_ADDR==RD_ADDR_x in the same cycle, and the write is legal, then RD_DATA_x <= WR_DATA (write-first).
- Out-of-range read address: RD_DATA_x <= 0.
- ZERO_REG=1 with RD_ADDR_x=0: RD_DATA_x <= 0.
- Scoreboard:
  - LOCK_EN=1 sets busy[LOCK_ADDR].
  - A legal write clears busy[WR_ADDR].
  - Lock and write to the same address in the same cycle: the lock wins and busy stays 1 (the new producer is pending).
  - Locks to out-of-range addresses, or to reg 0 when ZERO_REG=1, are ignored.
  - Locking an already-busy register leaves it busy. There is no counting; decode must not issue a second producer.
- BUSY_x = busy[RD_ADDR_x] & ~(legal WR_EN & WR_ADDR==RD_ADDR_x). This lets decode consume a register being written this cycle through the forwarding path. BUSY_x is 0 for out-of-range addresses.
- CLR=1 on posedge:
  - Zeroes all registers and busy bits, and sets RD_DATA_A/B <= 0.
  - Overrides WR_EN and LOCK_EN in the same cycle.
- Two ports reading the same address return identical data.
- Read-during-lock is unaffected: data is the current value; only BUSY signals staleness.

Decomposition:
- Shared package (constants): WORD_SIZE default, NUM_REGS default, and a typedef for the register-address type. The regfile imports it; the defaults here mirror it.
- One natural sub-module: reg_sb_bits, the busy-bit vector with set/clear priority and CLR, kept separate for standalone scoreboard checks.
- Storage and read ports stay in the top module.

Test Plan:
- Reset/idle: RST_N low for 2 cycles, then high; read addresses 0..7 -> RD_DATA=0 and BUSY=0 for all.
- Write/read latency: write 19'h5A5A5 to r3, then RD_ADDR_A=3 in the next cycle -> RD_DATA_A=19'h5A5A5 one cycle later. Port B reading r3 simultaneously -> same value.
- Forwarding: WR_EN, WR_ADDR=2, WR_DATA=19'h7FFFF with RD_ADDR_B=2 in the same cycle -> RD_DATA_B=19'h7FFFF next cycle, and BUSY_B=0 in that cycle even if r2 was locked.
- Scoreboard:
  - LOCK r5 -> BUSY_A=1 for RD_ADDR_A=5.
  - Write r5 and lock r5 in the same cycle -> BUSY stays 1.
  - A later write r5 alone -> BUSY_A=0.
- ZERO_REG=1 build: write 19'h00001 to r0 and lock r0 -> RD_DATA=0 and BUSY=0. With ZERO_REG=0, the same stimulus returns 19'h00001.
- Async reset and CLR:
  - Fill r1..r7 and lock r4, then drop RST_N mid-cycle -> outputs are 0 before the next edge.
  - Separately, CLR together with WR_EN to r6 -> r6 reads 0 and no busy bits are set.
